// File: rtl/standard_fifo.sv
// Standard (non-FWFT) synchronous FIFO with registered read data and
// registered empty/full flags. Depth is 2^ADDR_WIDTH words.
module standard_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_empty;
  logic                  r_full;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [ADDR_WIDTH-1:0] w_wptr_nxt;
  logic [ADDR_WIDTH-1:0] w_rptr_nxt;

  // Accept decode: a read frees a slot, so a write while full is taken
  // only when a read is accepted on the same edge.
  always_comb begin
    w_rd_acc   = rd & ~r_empty;
    w_wr_acc   = wr & (~r_full | w_rd_acc);
    w_wptr_nxt = r_wptr + ADDR_WIDTH'(1);
    w_rptr_nxt = r_rptr + ADDR_WIDTH'(1);
  end

  // Storage array: no reset; stale words are unreachable because the
  // pointers and empty flag are reset.
  always_ff @(posedge clk) begin
    if (reset && w_wr_acc) begin
      r_mem[r_wptr] <= w_data;
    end
  end

  // Pointers, read data register and occupancy flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rdata <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= w_wptr_nxt;
      end
      if (w_rd_acc) begin
        r_rptr  <= w_rptr_nxt;
        r_rdata <= r_mem[r_rptr];
      end
      // Simultaneous accepted read and write leaves occupancy unchanged.
      if (w_wr_acc && !w_rd_acc) begin
        r_empty <= 1'b0;
        r_full  <= (w_wptr_nxt == r_rptr);
      end else if (w_rd_acc && !w_wr_acc) begin
        r_full  <= 1'b0;
        r_empty <= (w_rptr_nxt == r_wptr);
      end
    end
  end

  assign r_data = r_rdata;
  assign empty  = r_empty;
  assign full   = r_full;

endmodule

// File: tb/tb_standard_fifo.sv
// Directed self-checking bench for standard_fifo (depth 16, 8-bit words).
module tb_standard_fifo;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          wr;
  logic          rd;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          empty;
  logic          full;

  int n_vec;
  int n_err;

  standard_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (rd),
    .w_data (w_data),
    .r_data (r_data),
    .empty  (empty),
    .full   (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Test word i shown as two decimal digits: 1..9 -> 0x01..0x09, 10..16 -> 0x10..0x16.
  function automatic logic [DW-1:0] pat(input int i);
    return DW'(((i / 10) << 4) | (i % 10));
  endfunction

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b0;
    wr     = 1'b1;
    rd     = 1'b1;
    w_data = 8'hEE;
    tick();
    tick();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_rdata", 32'(r_data), 32'h00);

    reset = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    tick();
    chk("idle_empty", 32'(empty), 32'd1);

    // Fill with 16 words.
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; w_data = pat(i);
      tick();
      wr = 1'b0;
      chk($sformatf("fill%0d_empty", i), 32'(empty), 32'd0);
      chk($sformatf("fill%0d_full", i), 32'(full), (i == 16) ? 32'd1 : 32'd0);
    end

    // 17th write while full is dropped.
    wr = 1'b1; w_data = 8'hAA;
    tick();
    wr = 1'b0;
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_empty", 32'(empty), 32'd0);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk($sformatf("drain%0d_data", i), 32'(r_data), 32'(pat(i)));
      chk($sformatf("drain%0d_full", i), 32'(full), 32'd0);
      chk($sformatf("drain%0d_empty", i), 32'(empty), (i == 16) ? 32'd1 : 32'd0);
    end

    // Read while empty is ignored.
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("udf_data", 32'(r_data), 32'h16);
    chk("udf_empty", 32'(empty), 32'd1);
    chk("udf_full", 32'(full), 32'd0);

    // Write 0x17, 0x18 then three reads.
    wr = 1'b1; w_data = 8'h17; tick();
    w_data = 8'h18; tick();
    wr = 1'b0;
    rd = 1'b1; tick();
    chk("r17_data", 32'(r_data), 32'h17);
    tick();
    chk("r18_data", 32'(r_data), 32'h18);
    tick();
    rd = 1'b0;
    chk("r18_hold", 32'(r_data), 32'h18);
    chk("r18_empty", 32'(empty), 32'd1);

    // Simultaneous wr/rd while empty: write only.
    wr = 1'b1; rd = 1'b1; w_data = 8'h19;
    tick();
    wr = 1'b0;
    chk("we_empty", 32'(empty), 32'd0);
    chk("we_data_hold", 32'(r_data), 32'h18);
    tick();
    rd = 1'b0;
    chk("we_read_data", 32'(r_data), 32'h19);
    chk("we_read_empty", 32'(empty), 32'd1);

    // Simultaneous wr/rd in the middle: occupancy unchanged.
    wr = 1'b1; w_data = 8'h30; tick();
    w_data = 8'h31; tick();
    rd = 1'b1; w_data = 8'h32; tick();
    wr = 1'b0;
    chk("mid_data", 32'(r_data), 32'h30);
    chk("mid_empty", 32'(empty), 32'd0);
    chk("mid_full", 32'(full), 32'd0);
    tick();
    chk("mid_r31", 32'(r_data), 32'h31);
    tick();
    rd = 1'b0;
    chk("mid_r32", 32'(r_data), 32'h32);
    chk("mid_empty_end", 32'(empty), 32'd1);

    // Refill across the wrap, then simultaneous wr/rd while full.
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'(8'h20 + i);
      tick();
    end
    wr = 1'b0;
    chk("refill_full", 32'(full), 32'd1);
    wr = 1'b1; rd = 1'b1; w_data = 8'h40;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk("fullrw_data", 32'(r_data), 32'h20);
    chk("fullrw_full", 32'(full), 32'd1);
    rd = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("wrap%0d_data", i), 32'(r_data), 32'(8'h20 + i));
    end
    tick();
    rd = 1'b0;
    chk("wrap_new_data", 32'(r_data), 32'h40);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Mid-operation reset discards contents.
    wr = 1'b1; w_data = 8'h51; tick();
    w_data = 8'h52; tick();
    wr = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_data", 32'(r_data), 32'h00);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("mrst_nostale", 32'(r_data), 32'h00);
    chk("mrst_nostale_empty", 32'(empty), 32'd1);
    wr = 1'b1; w_data = 8'h55; tick();
    wr = 1'b0; rd = 1'b1; tick();
    rd = 1'b0;
    chk("mrst_fresh_data", 32'(r_data), 32'h55);
    chk("mrst_fresh_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
